// File: rtl/decode_pkg.sv
// Shared opcode constants, instruction field positions and the decoded-class
// struct for the decode/issue stage.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 26;
    localparam int unsigned RS_MSB  = 25;
    localparam int unsigned RS_LSB  = 21;
    localparam int unsigned RT_MSB  = 20;
    localparam int unsigned RT_LSB  = 16;
    localparam int unsigned RD_MSB  = 15;
    localparam int unsigned RD_LSB  = 11;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [4:0] LINK_REG = 5'd31;

    typedef struct packed {
        logic       uses_rs;
        logic       uses_rt;
        logic [4:0] dest;
        logic       dest_valid;
        logic       zero_ext;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t       d;
        logic [5:0] opc;
        d   = '0;
        opc = instr[OPC_MSB:OPC_LSB];
        case (opc)
            OP_RTYPE: begin
                d.uses_rs = 1'b1;
                d.uses_rt = 1'b1;
                d.dest    = instr[RD_MSB:RD_LSB];
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
                d.uses_rs  = 1'b1;
                d.dest     = instr[RT_MSB:RT_LSB];
                d.zero_ext = (opc == OP_ANDI) || (opc == OP_ORI) || (opc == OP_XORI);
            end
            OP_SW, OP_BEQ, OP_BNE: begin
                d.uses_rs = 1'b1;
                d.uses_rt = 1'b1;
            end
            OP_JAL:  d.dest = LINK_REG;
            default: d = '0;
        endcase
        // Writes to r0 are discarded, so they never reserve a scoreboard bit.
        d.dest_valid = (d.dest != 5'd0);
        return d;
    endfunction

endpackage

// File: rtl/decode_issue_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue and cleared on
// writeback, with lookup ports for both sources and the destination.
module decode_issue_scoreboard #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              set_en_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic              clr_en_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    input  logic [ADDR_W-1:0] dest_addr_i,
    output logic              rs_busy_o,
    output logic              rt_busy_o,
    output logic              dest_busy_o
);

    localparam int unsigned NumRegs = 1 << ADDR_W;

    logic [NumRegs-1:0] pending_d, pending_q;

    always_comb begin
        pending_d = pending_q;
        if (clr_en_i) pending_d[clr_addr_i] = 1'b0;
        // Applied after the clear so a same-cycle set of the same register wins.
        if (set_en_i) pending_d[set_addr_i] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pending_q <= '0;
        else       pending_q <= pending_d;
    end

    assign rs_busy_o   = pending_q[rs_addr_i];
    assign rt_busy_o   = pending_q[rt_addr_i];
    assign dest_busy_o = pending_q[dest_addr_i];

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: drives regfile reads, captures operands with writeback
// bypass, stalls on scoreboard hazards and feeds execute via valid/ready.
module decode_issue
    import decode_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter bit          BYPASS_EN = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              InstrValid,
    output logic              InstrReady,
    input  logic [DATA_W-1:0] Instr,
    output logic [ADDR_W-1:0] ReadRegister1,
    output logic [ADDR_W-1:0] ReadRegister2,
    input  logic [DATA_W-1:0] ReadData1,
    input  logic [DATA_W-1:0] ReadData2,
    input  logic              WbValid,
    input  logic [ADDR_W-1:0] WbRegister,
    input  logic [DATA_W-1:0] WbData,
    output logic              ExValid,
    input  logic              ExReady,
    output logic [DATA_W-1:0] ExOpA,
    output logic [DATA_W-1:0] ExOpB,
    output logic [DATA_W-1:0] ExImm,
    output logic [ADDR_W-1:0] ExDest,
    output logic              ExDestValid,
    output logic [DATA_W-1:0] ExInstr
);

    dec_t              dec;
    logic [ADDR_W-1:0] rs, rt;
    logic              rs_busy, rt_busy, dest_busy;
    logic              rs_fwd, rt_fwd, hazard, accept;
    logic [DATA_W-1:0] op_a, op_b, imm;

    logic              ex_valid_q, ex_dest_valid_q;
    logic [DATA_W-1:0] ex_opa_q, ex_opb_q, ex_imm_q, ex_instr_q;
    logic [ADDR_W-1:0] ex_dest_q;

    assign dec = decode(Instr);
    assign rs  = Instr[RS_MSB:RS_LSB];
    assign rt  = Instr[RT_MSB:RT_LSB];

    assign ReadRegister1 = rs;
    assign ReadRegister2 = rt;

    // The regfile write lands on the same edge, so WbData is the fresh value.
    assign rs_fwd = BYPASS_EN && WbValid && (WbRegister == rs);
    assign rt_fwd = BYPASS_EN && WbValid && (WbRegister == rt);

    assign hazard = (dec.uses_rs && (rs != '0) && rs_busy && !rs_fwd)
                 || (dec.uses_rt && (rt != '0) && rt_busy && !rt_fwd)
                 || (dec.dest_valid && dest_busy);

    assign InstrReady = !Reset && !hazard && (!ex_valid_q || ExReady);
    assign accept     = InstrValid && InstrReady;

    always_comb begin
        op_a = '0;
        op_b = '0;
        if (dec.uses_rs && (rs != '0)) op_a = rs_fwd ? WbData : ReadData1;
        if (dec.uses_rt && (rt != '0)) op_b = rt_fwd ? WbData : ReadData2;
        imm = dec.zero_ext ? {{(DATA_W-16){1'b0}}, Instr[IMM_MSB:IMM_LSB]}
                           : {{(DATA_W-16){Instr[IMM_MSB]}}, Instr[IMM_MSB:IMM_LSB]};
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ex_valid_q      <= 1'b0;
            ex_opa_q        <= '0;
            ex_opb_q        <= '0;
            ex_imm_q        <= '0;
            ex_dest_q       <= '0;
            ex_dest_valid_q <= 1'b0;
            ex_instr_q      <= '0;
        end else if (accept) begin
            ex_valid_q      <= 1'b1;
            ex_opa_q        <= op_a;
            ex_opb_q        <= op_b;
            ex_imm_q        <= imm;
            ex_dest_q       <= dec.dest;
            ex_dest_valid_q <= dec.dest_valid;
            ex_instr_q      <= Instr;
        end else if (ExReady) begin
            ex_valid_q <= 1'b0;
        end
    end

    decode_issue_scoreboard #(
        .ADDR_W(ADDR_W)
    ) u_sb (
        .clk_i      (Clk),
        .rst_i      (Reset),
        .set_en_i   (accept && dec.dest_valid),
        .set_addr_i (dec.dest),
        .clr_en_i   (WbValid),
        .clr_addr_i (WbRegister),
        .rs_addr_i  (rs),
        .rt_addr_i  (rt),
        .dest_addr_i(dec.dest),
        .rs_busy_o  (rs_busy),
        .rt_busy_o  (rt_busy),
        .dest_busy_o(dest_busy)
    );

    assign ExValid     = ex_valid_q;
    assign ExOpA       = ex_opa_q;
    assign ExOpB       = ex_opb_q;
    assign ExImm       = ex_imm_q;
    assign ExDest      = ex_dest_q;
    assign ExDestValid = ex_dest_valid_q;
    assign ExInstr     = ex_instr_q;

endmodule

// File: doc/decode_issue.md
Name: decode_issue

Overview:
- Decode/issue stage sitting directly in front of the 32x32 register file (two read ports, one write port; register 0 hardwired to zero).
- Accepts 32-bit MIPS instructions from fetch and drives ReadRegister1/ReadRegister2.
- Captures operands with same-cycle writeback bypass and holds a 32-entry scoreboard to stall RAW/WAW hazards.
- Presents decoded operands to execute through a valid/ready pipeline register.

Parameters:
- DATA_W, 32, datapath/instruction width
- ADDR_W, 5, register address width (2^ADDR_W registers)
- BYPASS_EN, 1, 1 = forward WbData into operands on same-cycle writeback match; 0 = stall instead

Ports:
- Clk  in  1  clock, rising-edge
- Reset  in  1  asynchronous, active-high reset
- InstrValid  in  1  fetch presents Instr
- InstrReady  out  1  stage accepts Instr this cycle
- Instr  in  32  MIPS instruction word
- ReadRegister1  out  5  regfile port 1 address = Instr[25:21] (rs)
- ReadRegister2  out  5  regfile port 2 address = Instr[20:16] (rt)
- ReadData1  in  32  regfile port 1 data (combinational)
- ReadData2  in  32  regfile port 2 data (combinational)
- WbValid  in  1  writeback occurring this cycle (same signal drives regfile RegWrite)
- WbRegister  in  5  writeback destination
- WbData  in  32  writeback value
- ExValid  out  1  execute register holds a valid instruction
- ExReady  in  1  execute consumes the instruction this cycle
- ExOpA  out  32  rs operand
- ExOpB  out  32  rt operand
- ExImm  out  32  immediate; sign-extended, zero-extended for andi/ori/xori (0x0C/0x0D/0x0E)
- ExDest  out  5  destination register
- ExDestValid  out  1  instruction writes ExDest
- ExInstr  out  32  raw instruction word

Behaviour:
- Reset (async): ExValid=0, all Ex* data outputs=0, scoreboard=0. InstrReady=0 while Reset is high.
- Decode classes by opcode Instr[31:26]:
  - 0x00 R-type: reads rs,rt; dest rd=Instr[15:11]
  - 0x08,0x09,0x0A,0x0C,0x0D,0x0E,0x0F,0x23: reads rs; dest rt
  - 0x2B sw, 0x04 beq, 0x05 bne: reads rs,rt; no dest
  - 0x02 j: no reads, no dest
  - 0x03 jal: no reads; dest 31
  - Any other opcode: no reads, no dest, passed through unchanged.
- Dest 0 always gives ExDestValid=0.
- Read ports are driven from Instr combinationally every cycle, regardless of InstrValid.
- Operand select, per used source s:
  - s==0 → 0.
  - Else if BYPASS_EN and WbValid and WbRegister==s → WbData, because the regfile write lands on the same edge.
  - Else ReadData.
  - Unused sources capture 0.
- Hazard: any used source s≠0 with scoreboard[s]=1 is a hazard, unless (BYPASS_EN and WbValid and WbRegister==s). A valid dest whose scoreboard bit is set is also a hazard (WAW).
- InstrReady = !Reset and !hazard and (!ExValid or ExReady). Hazard is computed from Instr even when InstrValid=0.
- Accept = InstrValid and InstrReady. On accept:
  - ExValid<=1 and all Ex* fields load.
  - If the dest is valid, scoreboard[dest]<=1.
- Else if ExReady: ExValid<=0 and Ex* fields hold.
- Else: all Ex* outputs hold; they must be stable while ExValid and !ExReady.
- Scoreboard clear: on WbValid, scoreboard[WbRegister]<=0. WbRegister=0 is ignored.
  - If the same register is set and cleared in one cycle, the set wins.
  - A clear for a register not pending is harmless.
- Latency: an accepted instruction is visible on Ex* one cycle later. Throughput is 1 per cycle when there are no hazards and execute is ready.
- Boundary cases:
  - Back-to-back dependent instructions stall until the producer's writeback cycle; the consumer issues in that cycle via bypass, or the cycle after when BYPASS_EN=0.
  - Reset mid-stall drops the held instruction and clears all pending bits. Writebacks arriving after reset only clear bits.

Decomposition:
- Package decode_pkg holds:
  - opcode constants: OP_RTYPE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL
  - field bit ranges
  - the decoded-class struct {uses_rs, uses_rt, dest, dest_valid, zero_ext}
- Sub-module scoreboard: 32-bit pending vector with set/clear ports and two lookup ports plus a dest lookup. Async reset.

Test Plan:
- Reset, then issue addi r3,r0,7 (0x20030007) with ExReady=1 → next cycle: ExValid=1, ExOpA=0, ExImm=7, ExDest=3, ExDestValid=1; scoreboard[3]=1.
- With r3 pending, present add r4,r3,r3:
  - InstrReady=0 while pending.
  - Drive WbValid=1, WbRegister=3, WbData=7 (ReadData still returning the stale value) → accepted that cycle; ExOpA=ExOpB=7.
- ori r5,r0,0xFFFF → ExImm=0x0000FFFF. addi r5,r0,-1 → ExImm=0xFFFFFFFF.
- Hold ExReady=0 with ExValid=1 → InstrReady=0; Ex* outputs unchanged for 3 cycles; accept resumes the cycle ExReady=1.
- Write to r0 (addi r0,r0,3) → ExDestValid=0, no scoreboard bit set. A following read of r0 with ReadData1 forced 0xDEAD → ExOpA=0, no stall.
- Assert Reset for 1 cycle while stalled on r3 → ExValid=0, scoreboard all 0; the same add r4,r3,r3 is accepted immediately after Reset deasserts.
